// File: rtl/ina219_i2c_target.sv
// ---------------------------------------------------------------------------
// ina219_i2c_target
//
// I2C target that answers like an INA219 current/power monitor. The values
// returned for the shunt, bus, power and current registers come straight from
// input ports, so a sensor-reading master can be exercised end to end without
// real silicon. SCL and SDA are oversampled on i_clk (which must run at least
// 8x SCL) and SDA is only ever pulled low or released.
//
// Optional feature (macro INA_WRITE_EN):
//   defined   - MSB/LSB byte pairs written to pointer 0 update config and to
//               pointer 5 update calibration, on the ACK of the LSB.
//   undefined - every written data byte is ACKed and dropped; config and
//               calibration read back as CONFIG_RST / CAL_RST.
//
// Parameters:
//   SENSOR_ADDR  target address in 8-bit write form (bit 0 ignored)
//   CONFIG_RST   reset value of register 0x00 (config)
//   CAL_RST      reset value of register 0x05 (calibration)
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_scl          I2C clock from the master (input only)
//   io_sda         I2C data, open drain (0 or high-Z)
//   i_shunt_val    value returned for register 0x01
//   i_bus_val      value returned for register 0x02
//   i_power_val    value returned for register 0x03
//   i_current_val  value returned for register 0x04
//   o_reg_ptr      current register pointer
//   o_busy         high from address match until STOP or START
//   o_rd_done      one-clock pulse after each word's LSB has been shifted out
// ---------------------------------------------------------------------------
module ina219_i2c_target #(
    parameter logic [7:0]  SENSOR_ADDR = 8'h80,
    parameter logic [15:0] CONFIG_RST  = 16'h399F,
    parameter logic [15:0] CAL_RST     = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_scl,
    inout  wire         io_sda,
    input  logic [15:0] i_shunt_val,
    input  logic [15:0] i_bus_val,
    input  logic [15:0] i_power_val,
    input  logic [15:0] i_current_val,
    output logic [2:0]  o_reg_ptr,
    output logic        o_busy,
    output logic        o_rd_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_IGNORE,
        S_PTR,
        S_PTR_ACK,
        S_WR,
        S_WR_ACK,
        S_RD,
        S_MACK,
        S_WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizers and edge / condition detection.
    // Index 1 = SCL, index 0 = SDA. The idle bus level is high, so the
    // stages reset to 1.
    // ------------------------------------------------------------------
    logic [1:0] w_line_in;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] r_prev;
    logic [1:0] r_arm;

    assign w_line_in = {i_scl, io_sda};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 2'b11;
            r_sync <= 2'b11;
            r_prev <= 2'b11;
            r_arm  <= 2'd0;
        end else begin
            r_meta <= w_line_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    // Edge detection stays disarmed until the synchronizer has flushed its
    // reset value; otherwise leaving reset in the middle of a transfer with
    // SDA low and SCL high would look like a START.
    logic w_armed;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    assign w_armed    = (r_arm == 2'd3);
    assign w_sda      = r_sync[0];
    assign w_scl_rise = w_armed &  r_sync[1] & ~r_prev[1];
    assign w_scl_fall = w_armed & ~r_sync[1] &  r_prev[1];
    assign w_start    = w_armed & r_sync[1] & r_prev[1] &  r_prev[0] & ~r_sync[0];
    assign w_stop     = w_armed & r_sync[1] & r_prev[1] & ~r_prev[0] &  r_sync[0];

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t      r_state, w_state_next;
    logic [4:0]  r_bit_cnt, w_bit_cnt_next;
    logic [6:0]  r_rx, w_rx_next;
    logic        r_rw, w_rw_next;
    logic [15:0] r_tx, w_tx_next;
    logic        r_sda_low, w_sda_low_next;
    logic        r_busy, w_busy_next;
    logic        r_rd_done, w_rd_done_next;
    logic [2:0]  r_reg_ptr, w_reg_ptr_next;
    logic        r_ack_phase, w_ack_phase_next;

    logic [7:0]  w_byte;
    logic [15:0] w_config;
    logic [15:0] w_cal;
    logic [15:0] w_sel_value;

    assign w_byte = {r_rx, w_sda};

    // Register file view used for every snapshot.
    always_comb begin
        w_sel_value = 16'h0000;
        case (r_reg_ptr)
            3'd0:    w_sel_value = w_config;
            3'd1:    w_sel_value = i_shunt_val;
            3'd2:    w_sel_value = i_bus_val;
            3'd3:    w_sel_value = i_power_val;
            3'd4:    w_sel_value = i_current_val;
            3'd5:    w_sel_value = w_cal;
            default: w_sel_value = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 5'd0;
            r_rx        <= 7'd0;
            r_rw        <= 1'b0;
            r_tx        <= 16'h0000;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_done   <= 1'b0;
            r_reg_ptr   <= 3'd0;
            r_ack_phase <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_rx        <= w_rx_next;
            r_rw        <= w_rw_next;
            r_tx        <= w_tx_next;
            r_sda_low   <= w_sda_low_next;
            r_busy      <= w_busy_next;
            r_rd_done   <= w_rd_done_next;
            r_reg_ptr   <= w_reg_ptr_next;
            r_ack_phase <= w_ack_phase_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_rx_next        = r_rx;
        w_rw_next        = r_rw;
        w_tx_next        = r_tx;
        w_sda_low_next   = r_sda_low;
        w_busy_next      = r_busy;
        w_rd_done_next   = 1'b0;
        w_reg_ptr_next   = r_reg_ptr;
        w_ack_phase_next = r_ack_phase;

        if (w_start) begin
            w_state_next     = S_ADDR;
            w_bit_cnt_next   = 5'd0;
            w_sda_low_next   = 1'b0;
            w_busy_next      = 1'b0;
            w_ack_phase_next = 1'b0;
        end else if (w_stop) begin
            w_state_next     = S_IDLE;
            w_sda_low_next   = 1'b0;
            w_busy_next      = 1'b0;
            w_ack_phase_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_IGNORE, S_WAIT_STOP: begin
                    // only START/STOP move us out
                end

                // Byte reception shared by address, pointer and data bytes.
                S_ADDR, S_PTR, S_WR: begin
                    if (w_scl_rise) begin
                        w_rx_next      = w_byte[6:0];
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_bit_cnt_next   = 5'd0;
                            w_ack_phase_next = 1'b0;
                            case (r_state)
                                S_ADDR: begin
                                    if (w_byte[7:1] == SENSOR_ADDR[7:1]) begin
                                        w_state_next = S_ADDR_ACK;
                                        w_rw_next    = w_byte[0];
                                        w_busy_next  = 1'b1;
                                    end else begin
                                        w_state_next = S_IGNORE;
                                    end
                                end
                                S_PTR: begin
                                    w_reg_ptr_next = w_byte[2:0];
                                    w_state_next   = S_PTR_ACK;
                                end
                                default: w_state_next = S_WR_ACK;
                            endcase
                        end
                    end
                end

                // ACK slot: first falling edge pulls SDA low, second releases.
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            w_sda_low_next   = 1'b1;
                            w_ack_phase_next = 1'b1;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                w_tx_next = w_sel_value;
                            end
                        end else begin
                            w_ack_phase_next = 1'b0;
                            w_bit_cnt_next   = 5'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                // End of the ACK clock is also where the first
                                // data bit must appear.
                                w_state_next   = S_RD;
                                w_sda_low_next = ~r_tx[15];
                                w_tx_next      = {r_tx[14:0], 1'b0};
                                w_bit_cnt_next = 5'd1;
                            end else begin
                                w_sda_low_next = 1'b0;
                                w_state_next   = (r_state == S_ADDR_ACK) ? S_PTR : S_WR;
                            end
                        end
                    end
                end

                // Falling-edge slots 0-7: MSB bits, 8: release for the
                // master's ACK of the MSB (its value does not matter, the word
                // was snapshotted as a whole), 9-16: LSB bits, 17: release for
                // the master's ACK/NACK of the LSB.
                S_RD: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd8) begin
                            w_sda_low_next = 1'b0;
                        end else if (r_bit_cnt == 5'd17) begin
                            w_sda_low_next = 1'b0;
                            w_rd_done_next = 1'b1;
                            w_bit_cnt_next = 5'd0;
                            w_state_next   = S_MACK;
                        end else begin
                            w_sda_low_next = ~r_tx[15];
                            w_tx_next      = {r_tx[14:0], 1'b0};
                        end
                    end
                end

                S_MACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            // Same register again with fresh contents.
                            w_tx_next      = w_sel_value;
                            w_bit_cnt_next = 5'd0;
                            w_state_next   = S_RD;
                        end else begin
                            w_state_next = S_WAIT_STOP;
                        end
                    end
                end

                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Writable config / calibration
    // ------------------------------------------------------------------
`ifdef INA_WRITE_EN
    logic [15:0] r_config;
    logic [15:0] r_cal;
    logic [7:0]  r_wr_msb;
    logic [7:0]  r_wr_data;
    logic        r_pair_lsb;
    logic        w_wr_byte_done;
    logic        w_wr_ack_start;

    assign w_wr_byte_done = (r_state == S_WR) && w_scl_rise && (r_bit_cnt == 5'd7)
                            && !w_start && !w_stop;
    assign w_wr_ack_start = (r_state == S_WR_ACK) && !r_ack_phase && w_scl_fall
                            && !w_start && !w_stop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_config   <= CONFIG_RST;
            r_cal      <= CAL_RST;
            r_wr_msb   <= 8'h00;
            r_wr_data  <= 8'h00;
            r_pair_lsb <= 1'b0;
        end else begin
            if (w_wr_byte_done) begin
                r_wr_data <= w_byte;
            end
            // Pairing restarts with every new write transfer.
            if (r_state != S_WR && r_state != S_WR_ACK) begin
                r_pair_lsb <= 1'b0;
            end else if (w_wr_ack_start) begin
                if (!r_pair_lsb) begin
                    r_wr_msb   <= r_wr_data;
                    r_pair_lsb <= 1'b1;
                end else begin
                    r_pair_lsb <= 1'b0;
                    if (r_reg_ptr == 3'd0) begin
                        r_config <= {r_wr_msb, r_wr_data};
                    end else if (r_reg_ptr == 3'd5) begin
                        r_cal <= {r_wr_msb, r_wr_data};
                    end
                end
            end
        end
    end

    assign w_config = r_config;
    assign w_cal    = r_cal;
`else
    assign w_config = CONFIG_RST;
    assign w_cal    = CAL_RST;
`endif

    // Open drain: pull low or float, never drive high.
    assign io_sda    = r_sda_low ? 1'b0 : 1'bz;
    assign o_reg_ptr = r_reg_ptr;
    assign o_busy    = r_busy;
    assign o_rd_done = r_rd_done;

endmodule

// File: tb/tb_ina219_i2c_target.sv
`timescale 1ns/1ps
module tb_ina219_i2c_target;

    localparam int          T       = 40;            // quarter SCL period
    localparam logic [15:0] CFG_RST = 16'h399F;
    localparam logic [15:0] CAL_R   = 16'h0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl   = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda;
    logic [15:0] shunt, busv, power, current;
    logic [2:0]  reg_ptr;
    logic        busy, rd_done;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    ina219_i2c_target #(
        .SENSOR_ADDR (8'h80),
        .CONFIG_RST  (CFG_RST),
        .CAL_RST     (CAL_R)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_scl         (scl),
        .io_sda        (sda),
        .i_shunt_val   (shunt),
        .i_bus_val     (busv),
        .i_power_val   (power),
        .i_current_val (current),
        .o_reg_ptr     (reg_ptr),
        .o_busy        (busy),
        .o_rd_done     (rd_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int low_cnt = 0;    // cycles where SDA is low but the master is not pulling it
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (rd_done === 1'b1) rd_cnt++;
        if (sda === 1'b0 && !m_sda_low) low_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // reference register map
    logic [15:0] m_config;
    logic [15:0] m_cal;

    function automatic logic [15:0] model_val(input logic [2:0] p);
        case (p)
            3'd0:    return m_config;
            3'd1:    return shunt;
            3'd2:    return busv;
            3'd3:    return power;
            3'd4:    return current;
            3'd5:    return m_cal;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] p, input logic [7:0] q[$]);
`ifdef INA_WRITE_EN
        for (int i = 0; i + 1 < q.size(); i += 2) begin
            if (p == 3'd0) m_config = {q[i], q[i+1]};
            else if (p == 3'd5) m_cal = {q[i], q[i+1]};
        end
`else
        if (p == 3'd7 && q.size() > 1000) $display("unused");
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- bus master primitives (each leaves SCL low) ----------
    task automatic clk_bit(input logic b, output logic r);
        m_sda_low = ~b; #T;
        scl = 1'b1;     #T;
        r = sda;        #T;
        scl = 1'b0;     #T;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; #T;
        scl = 1'b1;       #T;
        m_sda_low = 1'b1; #T;
        scl = 1'b0;       #T;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #T;
        scl = 1'b1;       #T;
        m_sda_low = 1'b0; #T;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], x);
        clk_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mbit, output logic [7:0] d);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, x);
            d[i] = x;
        end
        clk_bit(mbit, x);
    endtask

    task automatic addr_ptr_rs(input logic [2:0] p, input string tag);
        logic a;
        i2c_start();
        send_byte(8'h80, a);           check({tag, "_wack"}, {31'd0, a}, 32'd0);
        send_byte({5'd0, p}, a);       check({tag, "_pack"}, {31'd0, a}, 32'd0);
        i2c_start();
        send_byte(8'h81, a);           check({tag, "_rack"}, {31'd0, a}, 32'd0);
    endtask

    task automatic read_word(input logic [2:0] p, input string tag, output logic [15:0] w);
        logic [7:0] hi, lo;
        addr_ptr_rs(p, tag);
        recv_byte(1'b0, hi);
        recv_byte(1'b1, lo);
        i2c_stop();
        w = {hi, lo};
    endtask

    task automatic write_bytes(input logic [2:0] p, input logic [7:0] q[$], input string tag);
        logic a;
        i2c_start();
        send_byte(8'h80, a);           check({tag, "_wack"}, {31'd0, a}, 32'd0);
        send_byte({5'd0, p}, a);       check({tag, "_pack"}, {31'd0, a}, 32'd0);
        foreach (q[i]) begin
            send_byte(q[i], a);        check({tag, "_dack"}, {31'd0, a}, 32'd0);
        end
        i2c_stop();
        model_write(p, q);
    endtask

    initial begin
        logic        a, x;
        logic [7:0]  b0, b1, b2, b3;
        logic [15:0] w, exp1, exp2;
        logic [7:0]  q[$];
        int          base, base_low, base_busy;

        m_config = CFG_RST;
        m_cal    = CAL_R;
        shunt    = 16'($urandom);
        busv     = 16'($urandom);
        power    = 16'($urandom);
        current  = 16'($urandom);

        // ---- reset state ----
        #23;
        check("rst_ptr",     {29'd0, reg_ptr}, 32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_rd_done", {31'd0, rd_done}, 32'd0);
        check("rst_sda",     {31'd0, sda},     32'd1);
        rst_n = 1'b1;
        #100;

        // ---- write ptr 4, repeated START, read current ----
        current = 16'h0259;
        base = rd_cnt;
        addr_ptr_rs(3'd4, "t1");
        check("t1_ptr",  {29'd0, reg_ptr}, 32'd4);
        check("t1_busy", {31'd0, busy},    32'd1);
        exp1 = model_val(3'd4);
        recv_byte(1'b0, b0);
        recv_byte(1'b1, b1);
        i2c_stop();
        #T;
        check("t1_word",      {16'd0, b0, b1}, {16'd0, exp1});
        check("t1_threshold", {31'd0, ({b0, b1} > 16'h0258)}, 32'd1);
        check("t1_rd_done",   rd_cnt - base, 32'd1);
        check("t1_busy_end",  {31'd0, busy}, 32'd0);
        $display("t1 read ptr4 word=%h", {b0, b1});

        // ---- foreign address is ignored ----
        base_low  = low_cnt;
        base_busy = busy_cnt;
        i2c_start();
        send_byte(8'h82, a);
        check("t2_nack", {31'd0, a}, 32'd1);
        send_byte(8'($urandom), a);
        i2c_stop();
        #T;
        check("t2_no_drive", low_cnt - base_low,   32'd0);
        check("t2_no_busy",  busy_cnt - base_busy, 32'd0);
        $display("t2 foreign address ignored");

        // ---- multi-word read, value changes mid-MSB ----
        busv = 16'h1234;
        addr_ptr_rs(3'd2, "t3");
        base = rd_cnt;
        exp1 = model_val(3'd2);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, x);
            b0[i] = x;
            if (i == 5) busv = 16'h5678;
        end
        clk_bit(1'b0, x);
        exp2 = model_val(3'd2);
        recv_byte(1'b0, b1);
        recv_byte(1'b0, b2);
        check("t3_rd_done_1", rd_cnt - base, 32'd1);
        recv_byte(1'b1, b3);
        i2c_stop();
        #T;
        check("t3_word1",     {16'd0, b0, b1}, {16'd0, exp1});
        check("t3_word2",     {16'd0, b2, b3}, {16'd0, exp2});
        check("t3_rd_done_2", rd_cnt - base, 32'd2);
        $display("t3 read ptr2 words=%h %h", {b0, b1}, {b2, b3});

        // ---- every pointer with random live values ----
        for (int p = 0; p < 8; p++) begin
            shunt   = 16'($urandom);
            busv    = 16'($urandom);
            power   = 16'($urandom);
            current = 16'($urandom);
            read_word(3'(p), "t4", w);
            check("t4_word", {16'd0, w}, {16'd0, model_val(3'(p))});
            $display("t4 read ptr%0d word=%h", p, w);
        end

        // ---- writes to cal, config (3 bytes) and a read-only pointer ----
        q = {8'h10, 8'h00};
        write_bytes(3'd5, q, "t5c");
        check("t5_ptr", {29'd0, reg_ptr}, 32'd5);
        read_word(3'd5, "t5c", w);
        check("t5_cal", {16'd0, w}, {16'd0, m_cal});
        $display("t5 cal readback=%h", w);
        q = {8'($urandom), 8'($urandom), 8'($urandom)};
        write_bytes(3'd0, q, "t5g");
        read_word(3'd0, "t5g", w);
        check("t5_config", {16'd0, w}, {16'd0, m_config});
        $display("t5 config readback=%h", w);
        q = {8'hDE, 8'hAD};
        write_bytes(3'd3, q, "t5p");
        read_word(3'd3, "t5p", w);
        check("t5_power", {16'd0, w}, {16'd0, model_val(3'd3)});
        $display("t5 power readback=%h", w);

        // ---- reset during 5th read bit ----
        current = 16'($urandom) & 16'hF7FF;    // bit 11 = 0 so SDA is pulled low
        addr_ptr_rs(3'd4, "t6");
        for (int i = 0; i < 4; i++) clk_bit(1'b1, x);
        m_sda_low = 1'b0; #T;
        scl = 1'b1;       #T;
        check("t6_pre_drive", {31'd0, sda}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_sda_release", {31'd0, sda},     32'd1);
        check("t6_ptr_reset",   {29'd0, reg_ptr}, 32'd0);
        m_config = CFG_RST;
        m_cal    = CAL_R;
        #(T-1);
        scl = 1'b0;       #T;
        rst_n = 1'b1;
        base_low  = low_cnt;
        base_busy = busy_cnt;
        for (int i = 0; i < 12; i++) clk_bit(1'b1, x);
        check("t6_no_drive", low_cnt - base_low,   32'd0);
        check("t6_no_busy",  busy_cnt - base_busy, 32'd0);
        i2c_stop();
        #T;
        read_word(3'd0, "t6", w);
        check("t6_config", {16'd0, w}, {16'd0, m_config});
        $display("t6 config after reset=%h", w);

        // ---- STOP while in the address ACK state ----
        i2c_start();
        for (int i = 7; i >= 1; i--) clk_bit(((8'h80 >> i) & 8'h01) != 0, x);
        m_sda_low = 1'b1; #T;        // R/W = 0
        scl = 1'b1;       #(T+20);
        check("t7_busy_match", {31'd0, busy}, 32'd1);
        m_sda_low = 1'b0;            // STOP
        #(T+20);
        check("t7_busy_clear", {31'd0, busy}, 32'd0);
        check("t7_sda_free",   {31'd0, sda},  32'd1);
        base_low = low_cnt;
        scl = 1'b0; #(2*T);
        scl = 1'b1; #(2*T);
        check("t7_no_ack", low_cnt - base_low, 32'd0);
        shunt = 16'($urandom);
        read_word(3'd1, "t7", w);
        check("t7_recover", {16'd0, w}, {16'd0, model_val(3'd1)});
        $display("t7 stop in addr ack, recovery word=%h", w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ina219_i2c_target.md
Name: ina219_i2c_target

Overview:
I2C target (responder) that emulates an INA219 register map. It is the far end of the sensor-reading I2C master used on each sensor bus. The block presents host-supplied shunt, bus, power and current values over I2C so the full sensor → relay → LCD path can be exercised in simulation or on a loop-back FPGA bus without real sensors. It oversamples SCL/SDA on the system clock and drives SDA open-drain only.

Parameters:
SENSOR_ADDR, 8'h80, target address in 8-bit write form; only bits [7:1] are compared.
CONFIG_RST, 16'h399F, reset value of register 0x00 (config).
CAL_RST, 16'h0000, reset value of register 0x05 (calibration).

Ports:
clk  input  1  system clock, must be at least 8x SCL.
rst_n  input  1  asynchronous active-low reset.
scl  input  1  I2C clock from master (never driven).
sda  inout  1  I2C data; driven 0 or high-Z, never 1.
shunt_val  input  16  value returned for register 0x01.
bus_val  input  16  value returned for register 0x02.
power_val  input  16  value returned for register 0x03.
current_val  input  16  value returned for register 0x04.
reg_ptr  output  3  current register pointer.
busy  output  1  high from address match until STOP or START.
rd_done  output  1  one-clk pulse after each LSB byte is shifted out.

Behaviour:
- Reset: all outputs 0, sda high-Z, reg_ptr=0, config=CONFIG_RST, cal=CAL_RST, state IDLE.
- scl and sda pass through 2-FF synchronizers. Edges are detected on the synchronized copies, giving 3-clk latency.
- START = sda falls while scl high. STOP = sda rises while scl high.
- START is honoured in any state, including repeated START: go to ADDR, bit count=0, release sda.
- STOP in any state: go to IDLE, release sda, busy=0.
- Bit sampling happens on scl rising edges. Target drives sda only on scl falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - If byte[7:1]==SENSOR_ADDR[7:1], go to ADDR_ACK.
    - Otherwise go to IGNORE (never drives sda until next START/STOP).
  - ADDR_ACK: pull sda low from the falling edge after bit 8 until the next falling edge. busy=1.
    - R/W=0: go to PTR.
    - R/W=1: snapshot the selected 16-bit register into the shift register at ACK start, then go to RD.
  - PTR: receive 8 bits. reg_ptr <= byte[2:0].
    - Pointer values 6–7 are ACKed, but reads from them return 16'h0000.
    - Then PTR_ACK, then WR.
  - WR: receive data bytes, ACK each (WR_ACK), return to WR.
  - RD: present a bit on each falling edge, MSB byte then LSB byte. Pulse rd_done on the falling edge after bit 16. Then go to MACK.
  - MACK: sample the master's bit on the rising edge.
    - ACK (0): re-snapshot the same register (values are live, no auto-increment) and continue RD.
    - NACK (1): release sda, go to WAIT_STOP.
  - WAIT_STOP: idle until STOP or START.
- A register snapshot is atomic. Input changes during a transfer do not affect bytes already in progress.
- Register 0x00 returns config; 0x05 returns cal.
- A reset assertion mid-transfer releases sda immediately (asynchronously) and restores the register reset values.

Optional Feature:
INA_WRITE_EN
- Defined: in WR, byte pairs (MSB then LSB) write config when reg_ptr=0 or cal when reg_ptr=5. The update happens on the ACK of the LSB. Writes to other pointers are ACKed and discarded. A third or later byte restarts the pairing.
- Undefined: all WR bytes are ACKed and discarded. config and cal stay at their parameter values.

Test Plan:
- Write 0x80, pointer 0x04, repeated START, read 0x81 with current_val=16'h0259, master ACK/NACK → bytes 0x02,0x59; both address ACKs low; rd_done pulses once; relay threshold path sees 0x0259 > 0x258.
- Address 0x82 sent to a target with SENSOR_ADDR=0x80 → sda never driven low; busy stays 0; later STOP is clean.
- Read of pointer 0x02 with master ACK after the LSB for 4 bytes, bus_val changed from 16'h1234 to 16'h5678 mid-MSB → bytes 12,34,56,78; each rd_done exactly once per word.
- INA_WRITE_EN defined: write ptr 0x05, bytes 0x10,0x00, then read back → 0x1000. Undefined → reads 0x0000.
- Assert rst_n low during the 5th read bit → sda high-Z within 0 clk; after release the target ignores the bus until a fresh START; config reads CONFIG_RST.
- STOP injected during ADDR_ACK → sda released on the STOP detect; state IDLE; busy=0.
